// File: rtl/axicb_wr_arbiter.sv
// AXI crossbar slave-port write arbiter: grants one AW at a time and routes W bursts in AW grant order.
// Define AXICB_WR_ARB_RR_EN for round-robin AW arbitration; otherwise the lowest index wins.
module axicb_wr_arbiter #(
  parameter int MST_NB      = 4,
  parameter int OSTDREQ_NUM = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         srst,
  input  logic [MST_NB-1:0]            req_awvalid,
  output logic [MST_NB-1:0]            req_awready,
  output logic                         slv_awvalid,
  input  logic                         slv_awready,
  output logic [MST_NB-1:0]            aw_grant,
  input  logic [MST_NB-1:0]            req_wvalid,
  input  logic [MST_NB-1:0]            req_wlast,
  output logic [MST_NB-1:0]            req_wready,
  output logic                         slv_wvalid,
  input  logic                         slv_wready,
  output logic [MST_NB-1:0]            w_grant,
  output logic [$clog2(OSTDREQ_NUM):0] ostd_cnt,
  output logic                         ostd_full
);

  localparam int IDX_W = $clog2(MST_NB);
  localparam int PTR_W = $clog2(OSTDREQ_NUM);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(OSTDREQ_NUM);
  localparam logic [MST_NB-1:0] ONE      = MST_NB'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_p0, state_nx;
  logic [MST_NB-1:0] grant_p0, grant_nx;
  logic [IDX_W-1:0]  gidx_p0, gidx_nx;
  logic [IDX_W-1:0]  start_idx, win_idx;
  logic              aw_hs, push, pop;

  logic [IDX_W-1:0]  q_mem [OSTDREQ_NUM];
  logic [PTR_W-1:0]  wr_ptr_p0, rd_ptr_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              q_empty;
  logic [IDX_W-1:0]  head;

  // First requester found when scanning upward from start, wrapping at MST_NB.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [MST_NB-1:0] vld,
                                                   input logic [IDX_W-1:0]  start);
    logic [2*MST_NB-1:0] dbl;
    logic [MST_NB-1:0]   rot;
    logic [IDX_W:0]      sum;
    logic                found;
    pick_winner = '0;
    found       = 1'b0;
    sum         = '0;
    dbl         = {vld, vld} >> start;
    rot         = dbl[MST_NB-1:0];
    for (int i = 0; i < MST_NB; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, start} + (IDX_W+1)'(i);
        if (sum >= (IDX_W+1)'(MST_NB)) sum = sum - (IDX_W+1)'(MST_NB);
        pick_winner = sum[IDX_W-1:0];
      end
    end
  endfunction

`ifdef AXICB_WR_ARB_RR_EN
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    next_idx = (idx == IDX_W'(MST_NB-1)) ? '0 : idx + IDX_W'(1);
  endfunction

  logic [IDX_W-1:0] rr_ptr_p0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)   rr_ptr_p0 <= '0;
    else if (srst)  rr_ptr_p0 <= '0;
    else if (aw_hs) rr_ptr_p0 <= next_idx(gidx_p0);
  end

  assign start_idx = rr_ptr_p0;
`else
  assign start_idx = '0;
`endif

  assign win_idx = pick_winner(req_awvalid, start_idx);

  // Stage p0: AW grant FSM (grant registered in IDLE, frozen in GRANT until handshake)
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_p0 <= IDLE;
      grant_p0 <= '0;
      gidx_p0  <= '0;
    end else if (srst) begin
      state_p0 <= IDLE;
      grant_p0 <= '0;
      gidx_p0  <= '0;
    end else begin
      state_p0 <= state_nx;
      grant_p0 <= grant_nx;
      gidx_p0  <= gidx_nx;
    end
  end

  always_comb begin
    state_nx    = state_p0;
    grant_nx    = grant_p0;
    gidx_nx     = gidx_p0;
    slv_awvalid = 1'b0;
    req_awready = '0;
    aw_hs       = 1'b0;
    case (state_p0)
      IDLE: begin
        if (|req_awvalid && !ostd_full) begin
          state_nx = GRANT;
          gidx_nx  = win_idx;
          grant_nx = ONE << win_idx;
        end
      end
      GRANT: begin
        slv_awvalid = |(req_awvalid & grant_p0);
        req_awready = grant_p0 & {MST_NB{slv_awready}};
        aw_hs       = slv_awvalid & slv_awready;
        if (aw_hs) begin
          state_nx = IDLE;
          grant_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign aw_grant = grant_p0;
  assign push     = aw_hs;

  // Stage p1: W-order queue of granted master indices; the head steers the W mux
  always_ff @(posedge aclk) begin
    if (push) q_mem[wr_ptr_p0] <= gidx_p0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      cnt_p0    <= '0;
    end else if (srst) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      cnt_p0    <= '0;
    end else begin
      if (push) wr_ptr_p0 <= wr_ptr_p0 + PTR_W'(1);
      if (pop)  rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_p0 <= cnt_p0 + CNT_W'(1);
        2'b01:   cnt_p0 <= cnt_p0 - CNT_W'(1);
        default: cnt_p0 <= cnt_p0;
      endcase
    end
  end

  assign q_empty   = (cnt_p0 == '0);
  assign head      = q_mem[rd_ptr_p0];
  assign ostd_cnt  = cnt_p0;
  assign ostd_full = (cnt_p0 == FULL_CNT);

  assign w_grant    = q_empty ? '0 : (ONE << head);
  assign slv_wvalid = !q_empty && req_wvalid[head];
  assign req_wready = w_grant & {MST_NB{slv_wready}};
  assign pop        = slv_wvalid & slv_wready & req_wlast[head];

endmodule

// File: tb/tb_axicb_wr_arbiter.sv
// Directed bench for axicb_wr_arbiter: per-cycle vector table plus hand-written arbitration,
// full-queue and backpressure/reset sequences.
module tb_axicb_wr_arbiter;

  localparam int MST_NB      = 4;
  localparam int OSTDREQ_NUM = 4;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       srst;
  logic [3:0] req_awvalid;
  logic [3:0] req_awready;
  logic       slv_awvalid;
  logic       slv_awready;
  logic [3:0] aw_grant;
  logic [3:0] req_wvalid;
  logic [3:0] req_wlast;
  logic [3:0] req_wready;
  logic       slv_wvalid;
  logic       slv_wready;
  logic [3:0] w_grant;
  logic [2:0] ostd_cnt;
  logic       ostd_full;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axicb_wr_arbiter #(.MST_NB(MST_NB), .OSTDREQ_NUM(OSTDREQ_NUM)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .req_awvalid(req_awvalid), .req_awready(req_awready),
    .slv_awvalid(slv_awvalid), .slv_awready(slv_awready), .aw_grant(aw_grant),
    .req_wvalid(req_wvalid), .req_wlast(req_wlast), .req_wready(req_wready),
    .slv_wvalid(slv_wvalid), .slv_wready(slv_wready), .w_grant(w_grant),
    .ostd_cnt(ostd_cnt), .ostd_full(ostd_full)
  );

  typedef struct packed {
    logic [3:0]  aw_v;
    logic        aw_r;
    logic [3:0]  w_v;
    logic [3:0]  w_l;
    logic        w_r;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] aw_v, input logic aw_r, input logic [3:0] w_v,
                              input logic [3:0] w_l, input logic w_r,
                              input logic e_awv, input logic [3:0] e_awg, input logic [3:0] e_awr,
                              input logic [3:0] e_wg, input logic e_wv, input logic [3:0] e_wr,
                              input logic [2:0] e_cnt, input logic e_full);
    vec_t v;
    v.aw_v = aw_v; v.aw_r = aw_r; v.w_v = w_v; v.w_l = w_l; v.w_r = w_r;
    v.exp  = {e_awv, e_awg, e_awr, e_wg, e_wv, e_wr, e_cnt, e_full};
    return v;
  endfunction

  function automatic logic [21:0] obs();
    return {slv_awvalid, aw_grant, req_awready, w_grant, slv_wvalid, req_wready, ostd_cnt, ostd_full};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req_awvalid = '0; slv_awready = 1'b0;
    req_wvalid  = '0; req_wlast   = '0; slv_wready = 1'b0;
  endtask

  task automatic pulse_srst();
    @(negedge aclk); clear_inputs(); srst = 1'b1;
    @(negedge aclk); srst = 1'b0;
  endtask

  task automatic do_aw(input int idx);
    bit done = 1'b0;
    for (int t = 0; t < 10 && !done; t++) begin
      @(negedge aclk);
      req_awvalid = 4'b0001 << idx;
      slv_awready = 1'b1;
      #1;
      if (slv_awvalid && aw_grant == (4'b0001 << idx)) done = 1'b1;
    end
    check($sformatf("aw_hs_m%0d", idx), 32'(done), 32'd1);
    @(negedge aclk);
    req_awvalid = '0;
    slv_awready = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_gnt [5];
    logic [3:0] got_gnt [5];
    int         n_got;

    aresetn = 1'b0; srst = 1'b0; clear_inputs();

    // Per-cycle vectors: {aw_v, aw_r, w_v, w_l, w_r} -> {slv_awv, aw_grant, req_awready, w_grant, slv_wv, req_wready, cnt, full}
    // Master 2: AW then 4-beat W
    vecs.push_back(mk(4'b0100,1'b0,4'b0000,4'b0000,1'b0, 1'b0,4'b0000,4'b0000,4'b0000,1'b0,4'b0000,3'd0,1'b0));
    vecs.push_back(mk(4'b0100,1'b1,4'b0000,4'b0000,1'b0, 1'b1,4'b0100,4'b0100,4'b0000,1'b0,4'b0000,3'd0,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b0100,4'b0000,1'b1, 1'b0,4'b0000,4'b0000,4'b0100,1'b1,4'b0100,3'd1,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b0100,4'b0000,1'b1, 1'b0,4'b0000,4'b0000,4'b0100,1'b1,4'b0100,3'd1,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b0100,4'b0000,1'b1, 1'b0,4'b0000,4'b0000,4'b0100,1'b1,4'b0100,3'd1,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b0100,4'b0100,1'b1, 1'b0,4'b0000,4'b0000,4'b0100,1'b1,4'b0100,3'd1,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,4'b0000,1'b0, 1'b0,4'b0000,4'b0000,4'b0000,1'b0,4'b0000,3'd0,1'b0));
    // W ordering: AW to 1 then 3; master 3 offers W early and must wait
    vecs.push_back(mk(4'b0010,1'b0,4'b0000,4'b0000,1'b0, 1'b0,4'b0000,4'b0000,4'b0000,1'b0,4'b0000,3'd0,1'b0));
    vecs.push_back(mk(4'b0010,1'b1,4'b0000,4'b0000,1'b0, 1'b1,4'b0010,4'b0010,4'b0000,1'b0,4'b0000,3'd0,1'b0));
    vecs.push_back(mk(4'b1000,1'b1,4'b1000,4'b0000,1'b1, 1'b0,4'b0000,4'b0000,4'b0010,1'b0,4'b0010,3'd1,1'b0));
    vecs.push_back(mk(4'b1000,1'b1,4'b1000,4'b0000,1'b1, 1'b1,4'b1000,4'b1000,4'b0010,1'b0,4'b0010,3'd1,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b1010,4'b0010,1'b1, 1'b0,4'b0000,4'b0000,4'b0010,1'b1,4'b0010,3'd2,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b1000,4'b1000,1'b1, 1'b0,4'b0000,4'b0000,4'b1000,1'b1,4'b1000,3'd1,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,4'b0000,1'b0, 1'b0,4'b0000,4'b0000,4'b0000,1'b0,4'b0000,3'd0,1'b0));
    // Simultaneous push/pop at occupancy 2
    vecs.push_back(mk(4'b0001,1'b0,4'b0000,4'b0000,1'b0, 1'b0,4'b0000,4'b0000,4'b0000,1'b0,4'b0000,3'd0,1'b0));
    vecs.push_back(mk(4'b0001,1'b1,4'b0000,4'b0000,1'b0, 1'b1,4'b0001,4'b0001,4'b0000,1'b0,4'b0000,3'd0,1'b0));
    vecs.push_back(mk(4'b0010,1'b0,4'b0000,4'b0000,1'b0, 1'b0,4'b0000,4'b0000,4'b0001,1'b0,4'b0000,3'd1,1'b0));
    vecs.push_back(mk(4'b0010,1'b1,4'b0000,4'b0000,1'b0, 1'b1,4'b0010,4'b0010,4'b0001,1'b0,4'b0000,3'd1,1'b0));
    vecs.push_back(mk(4'b0100,1'b0,4'b0000,4'b0000,1'b0, 1'b0,4'b0000,4'b0000,4'b0001,1'b0,4'b0000,3'd2,1'b0));
    vecs.push_back(mk(4'b0100,1'b1,4'b0001,4'b0001,1'b1, 1'b1,4'b0100,4'b0100,4'b0001,1'b1,4'b0001,3'd2,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,4'b0000,1'b0, 1'b0,4'b0000,4'b0000,4'b0010,1'b0,4'b0000,3'd2,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b0010,4'b0010,1'b1, 1'b0,4'b0000,4'b0000,4'b0010,1'b1,4'b0010,3'd2,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b0100,4'b0100,1'b1, 1'b0,4'b0000,4'b0000,4'b0100,1'b1,4'b0100,3'd1,1'b0));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,4'b0000,1'b0, 1'b0,4'b0000,4'b0000,4'b0000,1'b0,4'b0000,3'd0,1'b0));

    // Reset state
    repeat (2) @(negedge aclk);
    #1;
    check("reset_outputs", 32'(obs()), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("post_reset_idle", 32'(obs()), 32'd0);

    foreach (vecs[i]) begin
      @(negedge aclk);
      req_awvalid = vecs[i].aw_v;
      slv_awready = vecs[i].aw_r;
      req_wvalid  = vecs[i].w_v;
      req_wlast   = vecs[i].w_l;
      slv_wready  = vecs[i].w_r;
      #1;
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // All masters request continuously; W drains one single-beat burst per cycle
    pulse_srst();
`ifdef AXICB_WR_ARB_RR_EN
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    n_got = 0;
    for (int t = 0; t < 40 && n_got < 5; t++) begin
      @(negedge aclk);
      req_awvalid = 4'b1111; slv_awready = 1'b1;
      req_wvalid  = 4'b1111; req_wlast   = 4'b1111; slv_wready = 1'b1;
      #1;
      if (slv_awvalid && slv_awready) begin
        got_gnt[n_got] = aw_grant;
        n_got++;
      end
    end
    check("arb_grant_count", 32'(n_got), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < n_got) check($sformatf("arb_order%0d", k), 32'(got_gnt[k]), 32'(exp_gnt[k]));
    end

    // Queue full blocks new grants until a pop
    pulse_srst();
    for (int m = 0; m < 4; m++) do_aw(m);
    @(negedge aclk);
    #1;
    check("full_cnt", 32'({ostd_full, ostd_cnt}), 32'({1'b1, 3'd4}));
    for (int t = 0; t < 3; t++) begin
      @(negedge aclk);
      req_awvalid = 4'b0001; slv_awready = 1'b1;
      #1;
      check($sformatf("full_block%0d", t), 32'({slv_awvalid, aw_grant}), 32'd0);
    end
    @(negedge aclk);
    req_wvalid = 4'b0001; req_wlast = 4'b0001; slv_wready = 1'b1;
    #1;
    check("full_pop_beat", 32'({slv_wvalid, w_grant}), 32'({1'b1, 4'b0001}));
    @(negedge aclk);
    req_wvalid = '0; req_wlast = '0; slv_wready = 1'b0;
    #1;
    check("after_pop", 32'({ostd_full, ostd_cnt, aw_grant}), 32'({1'b0, 3'd3, 4'b0000}));
    @(negedge aclk);
    #1;
    check("fifth_aw_grant", 32'({slv_awvalid, aw_grant}), 32'({1'b1, 4'b0001}));
    @(negedge aclk);
    req_awvalid = '0; slv_awready = 1'b0;
    #1;
    check("refull_cnt", 32'({ostd_full, ostd_cnt}), 32'({1'b1, 3'd4}));

    // Slave AW backpressure, then asynchronous reset mid-hold
    pulse_srst();
    do_aw(1);
    @(negedge aclk);
    req_awvalid = 4'b0100; slv_awready = 1'b0;
    req_wvalid  = 4'b0010; req_wlast   = 4'b0000; slv_wready = 1'b1;
    #1;
    check("bp_idle", 32'({slv_awvalid, aw_grant, w_grant}), 32'({1'b0, 4'b0000, 4'b0010}));
    for (int t = 0; t < 5; t++) begin
      @(negedge aclk);
      #1;
      check($sformatf("bp_hold%0d", t), 32'({slv_awvalid, aw_grant, req_awready}),
            32'({1'b1, 4'b0100, 4'b0000}));
    end
    aresetn = 1'b0;
    #1;
    check("async_reset_outputs", 32'(obs()), 32'd0);
    @(negedge aclk);
    clear_inputs();
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    check("post_async_reset", 32'(obs()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
